// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master between NUM_REQ requesters with
// round-robin arbitration, and sequences each granted transaction.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   Defined: an XFER that sees no m_done for TIMEOUT_CYCLES cycles is aborted
//   with err pulsed alongside ack and rdata forced to 0.
//   Undefined: XFER waits for m_done indefinitely and err is tied low.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   req         - per-requester request level, held until its ack
//   req_mode    - per-requester mode (1 = READ, 0 = WRITE)
//   req_wdata   - per-requester write byte, requester i at [i*DATA_W +: DATA_W]
//   ack         - one-cycle completion pulse to the granted requester
//   rdata       - read byte of the last completed transaction
//   err         - high with ack when the transaction timed out
//   busy        - high while a transaction is in flight
//   grant_id    - current or last granted requester
//   m_start     - start level to the SPI master
//   m_mode      - mode to the SPI master
//   m_wdata     - write byte to the SPI master
//   m_done      - completion pulse from the SPI master
//   m_rdata     - read byte from the SPI master, valid with m_done
module spi_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_mode,
  input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_W-1:0]              rdata,
  output logic                           err,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           m_start,
  output logic                           m_mode,
  output logic [DATA_W-1:0]              m_wdata,
  input  logic                           m_done,
  input  logic [DATA_W-1:0]              m_rdata
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e         state;
  logic [IdW-1:0] last;

  // Round-robin pick: first set req bit searching upward from last+1.
  logic              any_req;
  logic [IdW-1:0]    pick;
  logic              pick_mode;
  logic [DATA_W-1:0] pick_wdata;
  logic [IdW:0]      cand_sum;
  logic [IdW-1:0]    cand;

  always_comb begin
    any_req    = 1'b0;
    pick       = last;
    pick_mode  = 1'b0;
    pick_wdata = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand_sum = {1'b0, last} + (IdW+1)'(i);
      if (cand_sum >= (IdW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IdW+1)'(NUM_REQ);
      end
      cand = cand_sum[IdW-1:0];
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick == IdW'(i)) begin
        pick_mode  = req_mode[i];
        pick_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      last     <= IdW'(NUM_REQ - 1);
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      m_start  <= 1'b0;
      m_mode   <= 1'b0;
      m_wdata  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err      <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      // ack and err are single-cycle pulses.
      ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (any_req) begin
            grant_id <= pick;
            m_mode   <= pick_mode;
            m_wdata  <= pick_wdata;
            m_start  <= 1'b1;
            last     <= pick;
            busy     <= 1'b1;
            state    <= StXfer;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        StXfer: begin
          // m_done takes priority over a coincident timeout.
          if (m_done) begin
            rdata   <= m_rdata;
            m_start <= 1'b0;
            ack     <= NUM_REQ'(1) << grant_id;
            state   <= StResp;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            rdata   <= '0;
            err     <= 1'b1;
            m_start <= 1'b0;
            ack     <= NUM_REQ'(1) << grant_id;
            state   <= StResp;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        StResp: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed testbench for spi_req_arbiter: single read, write, round-robin
// order, fairness, asynchronous reset mid-transfer and (with
// SPI_ARB_TIMEOUT_EN defined) the transfer timeout.
module tb_spi_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif
  // Keep the long read shorter than the timeout when the timeout is enabled.
  localparam int T1Wait = (TO > 21) ? 19 : 10;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_mode;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             busy;
  logic [1:0]       grant_id;
  logic             m_start;
  logic             m_mode;
  logic [DW-1:0]    m_wdata;
  logic             m_done;
  logic [DW-1:0]    m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  spi_req_arbiter #(
    .NUM_REQ       (NR),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_mode (req_mode),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy),
    .grant_id (grant_id),
    .m_start  (m_start),
    .m_mode   (m_mode),
    .m_wdata  (m_wdata),
    .m_done   (m_done),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Master completes the current transfer on the next edge.
  task automatic complete(input logic [DW-1:0] rd);
    m_done  = 1'b1;
    m_rdata = rd;
    step();
    m_done  = 1'b0;
    m_rdata = '0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int order3[5] = '{0, 1, 2, 3, 0};
  int order4[4] = '{0, 2, 0, 2};

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_mode  = '0;
    req_wdata = '0;
    m_done    = 1'b0;
    m_rdata   = '0;
    step();
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_mode", 32'(m_mode), 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_no_req_start", 32'(m_start), 32'd0);

    // Single READ from requester 0.
    req       = 4'b0001;
    req_mode  = 4'b0001;
    req_wdata = {8'h00, 8'h00, 8'h00, 8'hAB};
    step();
    chk("t1_start", 32'(m_start), 32'd1);
    chk("t1_mode", 32'(m_mode), 32'd1);
    chk("t1_wdata", 32'(m_wdata), 32'hAB);
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_no_ack_yet", 32'(ack), 32'd0);
    repeat (T1Wait) step();
    chk("t1_hold_start", 32'(m_start), 32'd1);
    chk("t1_hold_wdata", 32'(m_wdata), 32'hAB);
    complete(8'h5C);
    chk("t1_ack", 32'(ack), 32'b0001);
    chk("t1_rdata", 32'(rdata), 32'h5C);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_start_off", 32'(m_start), 32'd0);
    chk("t1_busy_resp", 32'(busy), 32'd1);
    req = '0;
    step();
    chk("t1_ack_clear", 32'(ack), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_gid_hold", 32'(grant_id), 32'd0);

    // m_done outside XFER is ignored.
    m_done  = 1'b1;
    m_rdata = 8'hEE;
    step();
    m_done  = 1'b0;
    m_rdata = '0;
    chk("stray_ack", 32'(ack), 32'd0);
    chk("stray_rdata", 32'(rdata), 32'h5C);
    chk("stray_busy", 32'(busy), 32'd0);

    // WRITE from requester 2; changes after grant have no effect.
    req       = 4'b0100;
    req_mode  = 4'b0000;
    req_wdata = {8'h00, 8'h3F, 8'h00, 8'h00};
    step();
    chk("t2_grant_id", 32'(grant_id), 32'd2);
    chk("t2_mode", 32'(m_mode), 32'd0);
    chk("t2_wdata", 32'(m_wdata), 32'h3F);
    chk("t2_start", 32'(m_start), 32'd1);
    req_mode  = 4'b0100;
    req_wdata = {8'h00, 8'hC4, 8'h00, 8'h00};
    req       = '0;
    repeat (3) step();
    chk("t2_mode_stable", 32'(m_mode), 32'd0);
    chk("t2_wdata_stable", 32'(m_wdata), 32'h3F);
    complete(8'h11);
    chk("t2_ack", 32'(ack), 32'b0100);
    chk("t2_rdata", 32'(rdata), 32'h11);
    step();

    // All four held after reset: order 0,1,2,3,0 with a two-cycle start gap.
    reset_pulse();
    req       = 4'b1111;
    req_mode  = 4'b0000;
    req_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_grant_id", 32'(grant_id), 32'(order3[k]));
      chk("t3_start", 32'(m_start), 32'd1);
      chk("t3_wdata", 32'(m_wdata), 32'(8'h10 + order3[k]));
      repeat (2) step();
      complete(8'(8'h40 + k));
      chk("t3_ack", 32'(ack), 32'(1) << order3[k]);
      chk("t3_rdata", 32'(rdata), 32'(8'h40 + k));
      chk("t3_gap1", 32'(m_start), 32'd0);
      if (k == 4) req = '0;
      step();
      chk("t3_gap2", 32'(m_start), 32'd0);
    end

    // Fairness: req0 held, req2 raised during req0's first transfer.
    reset_pulse();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_grant_id", 32'(grant_id), 32'(order4[k]));
      if (k == 0) req = 4'b0101;
      step();
      complete(8'h20);
      chk("t4_ack", 32'(ack), 32'(1) << order4[k]);
      if (k == 3) req = '0;
      step();
    end

    // Reset mid-XFER, then pointer must be back at NUM_REQ-1.
    req = 4'b0010;
    step();
    chk("t5_grant_id", 32'(grant_id), 32'd1);
    chk("t5_start", 32'(m_start), 32'd1);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("t5_async_start", 32'(m_start), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    chk("t5_ptr_reset_gid", 32'(grant_id), 32'd1);
    chk("t5_regrant_start", 32'(m_start), 32'd1);
    complete(8'h77);
    chk("t5_ack", 32'(ack), 32'b0010);
    req = 4'b1000;
    step();
    step();
    chk("t5_gid3", 32'(grant_id), 32'd3);
    complete(8'h78);
    chk("t5_ack3", 32'(ack), 32'b1000);
    chk("t5_err", 32'(err), 32'd0);
    req = '0;
    step();

`ifdef SPI_ARB_TIMEOUT_EN
    // No m_done: abort exactly TO cycles after m_start rose.
    req = 4'b0001;
    step();
    chk("to_start", 32'(m_start), 32'd1);
    req = '0;
    repeat (TO - 1) step();
    chk("to_not_yet", 32'(ack), 32'd0);
    step();
    chk("to_ack", 32'(ack), 32'b0001);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", 32'(rdata), 32'd0);
    chk("to_start_off", 32'(m_start), 32'd0);
    step();
    chk("to_err_clear", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
